debouncer_pulse: RTL and testbench

Push-button debouncer that converts a raw, bouncing, asynchronous button input into a single-clock-cycle press pulse. The input is synchronised, then a state machine requires it to be stable high for a programmable time before emitting the pulse. Releases are debounced the same way but produce no pulse. Sits between board button pins and control logic such as stopwatch start/stop/clear.

---
 rtl/debouncer_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/debouncer_pulse.sv | 95 +++++++++
 tb/tb_debouncer_pulse.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// debouncer_pkg: shared types and helpers for the push-button debouncer.
//   state_t : debounce FSM state (2-bit encoding)
//   calc_n  : stable-time length in clock cycles, never less than 1
package debouncer_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,  // debounced low
    WAIT1 = 2'd1,  // rising, waiting for stable high
    ONE   = 2'd2,  // debounced high
    WAIT0 = 2'd3   // falling, waiting for stable low
  } state_t;

  function automatic int unsigned calc_n(input int unsigned clk_period_ns,
                                         input int unsigned delay_ns);
    int unsigned n;
    n = delay_ns / clk_period_ns;
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
//   clk_i : clock
//   rst_i : synchronous active-high reset, clears both flops to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output (two cycles of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1;
  logic s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d_i;
      s2 <= s1;
    end
  end

  assign q_o = s2;

endmodule

// File: rtl/debouncer_pulse.sv
// debouncer_pulse: debounces a raw button and emits a one-cycle pulse per
// debounced press. Releases are debounced the same way but give no pulse.
//   clk_i   : clock, all logic on rising edge
//   rst_i   : synchronous active-high reset
//   btn_i   : raw asynchronous button level, high = pressed
//   pulse_o : registered one-cycle pulse on each debounced press
//   level_o : debounced level (only when DEBOUNCER_LEVEL_OUT_EN is defined)
// Parameters: CLK_PERIOD_NS, DELAY_NS; stable time N = DELAY_NS/CLK_PERIOD_NS
// clamped to at least 1.
module debouncer_pulse
  import debouncer_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS = 10,
  parameter int unsigned DELAY_NS      = 20000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
`ifdef DEBOUNCER_LEVEL_OUT_EN
  ,
  output logic level_o
`endif
);

  localparam int unsigned N     = calc_n(CLK_PERIOD_NS, DELAY_NS);
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic             s2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_next;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (s2)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ZERO;
      cnt     <= '0;
      pulse_o <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pulse_o <= pulse_next;
    end
  end

  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    unique case (state)
      ZERO:  if (s2) state_next = WAIT1;
      WAIT1: begin
        if (!s2) begin
          state_next = ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next = ONE;
          pulse_next = 1'b1;
        end
      end
      ONE:   if (!s2) state_next = WAIT0;
      WAIT0: begin
        if (s2) begin
          state_next = ONE;
        end else if (cnt == CNT_LAST) begin
          state_next = ZERO;
        end
      end
      default: state_next = ZERO;
    endcase
  end

  // Counter restarts on any state change; it only advances while waiting.
  always_comb begin
    cnt_next = cnt;
    if (state_next != state) begin
      cnt_next = '0;
    end else if (state == WAIT1 || state == WAIT0) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

`ifdef DEBOUNCER_LEVEL_OUT_EN
  assign level_o = (state == ONE) || (state == WAIT0);
`endif

endmodule

// File: tb/tb_debouncer_pulse.sv
// tb_debouncer_pulse: directed bench for debouncer_pulse with N = 100.
// Define DEBOUNCER_LEVEL_OUT_EN to also exercise level_o.
module tb_debouncer_pulse;
  import debouncer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic pulse;
`ifdef DEBOUNCER_LEVEL_OUT_EN
  logic level;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debouncer_pulse #(
    .CLK_PERIOD_NS (10),
    .DELAY_NS      (1000)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn),
    .pulse_o (pulse)
`ifdef DEBOUNCER_LEVEL_OUT_EN
    ,
    .level_o (level)
`endif
  );

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Holds btn at lvl for the given number of cycles. Index 0 is the first
  // rising edge that samples the new level; outputs are sampled 1ns after
  // each edge. Reports pulse count, first pulse index and first indices at
  // which level_o was seen high / low (-1 if never).
  task automatic drive(input logic lvl, input int cycles, output int pulses,
                       output int first, output int lvl_hi, output int lvl_lo);
    btn    = lvl;
    pulses = 0;
    first  = -1;
    lvl_hi = -1;
    lvl_lo = -1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
`ifdef DEBOUNCER_LEVEL_OUT_EN
      if (level === 1'b1 && lvl_hi < 0) lvl_hi = i;
      if (level !== 1'b1 && lvl_lo < 0) lvl_lo = i;
`endif
    end
  endtask

  int p, f, lh, ll, acc;

  initial begin
    // Reset for 3 cycles
    rst = 1'b1;
    drive(1'b0, 3, p, f, lh, ll);
    check("reset_pulse", int'(pulse), 0);
    check("reset_state", int'(dut.state), int'(ZERO));
`ifdef DEBOUNCER_LEVEL_OUT_EN
    check("reset_level", lh, -1);
`endif
    rst = 1'b0;

    // Idle low
    drive(1'b0, 1000, p, f, lh, ll);
    check("idle_pulses", p, 0);

    // Short bounce sequence
    acc = 0;
    drive(1'b0, 8, p, f, lh, ll);    acc += p;
    drive(1'b1, 5, p, f, lh, ll);    acc += p;
    drive(1'b0, 5, p, f, lh, ll);    acc += p;
    drive(1'b1, 5, p, f, lh, ll);    acc += p;
    drive(1'b0, 2000, p, f, lh, ll); acc += p;
    check("bounce_pulses", acc, 0);
    check("bounce_state", int'(dut.state), int'(ZERO));

    // High for N cycles: s2 high for only N edges, rejected
    drive(1'b1, 100, p, f, lh, ll); acc = p;
    drive(1'b0, 300, p, f, lh, ll); acc += p;
    check("glitch_n_pulses", acc, 0);

    // High for N+1 cycles: just long enough, pulse at index 102 overall
    drive(1'b1, 101, p, f, lh, ll);
    check("n1_pulse_in_press", p, 0);
    drive(1'b0, 300, p, f, lh, ll);
    check("n1_pulse_count", p, 1);
    check("n1_pulse_index", f, 1);

    // Long hold: exactly one pulse at index 102
    drive(1'b1, 500, p, f, lh, ll);
    check("hold_pulse_count", p, 1);
    check("hold_pulse_index", f, 102);
`ifdef DEBOUNCER_LEVEL_OUT_EN
    check("hold_level_rise", lh, 102);
    check("hold_level_end", int'(level), 1);
`endif

    // Bouncy release: no pulse, level stays high through bounces
    acc = 0;
    ll  = -1;
    for (int b = 0; b < 3; b++) begin
      drive(1'b0, 5, p, f, lh, ll); acc += p;
`ifdef DEBOUNCER_LEVEL_OUT_EN
      check("rel_bounce_level_lo", ll, -1);
`endif
      drive(1'b1, 5, p, f, lh, ll); acc += p;
    end
    drive(1'b0, 200, p, f, lh, ll); acc += p;
    check("release_pulses", acc, 0);
    check("release_state", int'(dut.state), int'(ZERO));
`ifdef DEBOUNCER_LEVEL_OUT_EN
    check("release_level_fall", ll, 102);
`endif

    // Second press
    drive(1'b1, 200, p, f, lh, ll);
    check("press2_pulse_count", p, 1);
    check("press2_pulse_index", f, 102);

    // Reset mid-press: full latency restarts after reset
    drive(1'b0, 300, p, f, lh, ll);
    check("pre_rst_release", p, 0);
    drive(1'b1, 50, p, f, lh, ll);
    check("pre_rst_press", p, 0);
    rst = 1'b1;
    drive(1'b1, 1, p, f, lh, ll);
    check("rst_cycle_pulse", p, 0);
    check("rst_cycle_state", int'(dut.state), int'(ZERO));
`ifdef DEBOUNCER_LEVEL_OUT_EN
    check("rst_cycle_level", lh, -1);
`endif
    rst = 1'b0;
    drive(1'b1, 200, p, f, lh, ll);
    check("post_rst_pulse_count", p, 1);
    check("post_rst_pulse_index", f, 102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
